// File: rtl/cook_timer_countdown.sv
// Microwave cook-time counter: keypad digits shift into a BCD MM:SS
// register and count down once per second while the magnetron runs.
module cook_timer_countdown #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic          time_zero;
    logic          run;
    logic          tick;
    logic          entry_ok;
    logic [3:0]    d_mt, d_mo, d_st, d_so;
    logic          dec_zero;

    assign time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign run       = mag_on && !time_zero;
    assign tick      = run && (presc == PMAX);
    assign entry_ok  = !mag_on && digit_valid && (digit <= 4'd9);

    // BCD decrement with borrow; sec_tens reloads as 5 on a minute borrow
    always_comb begin
        d_mt = min_tens;
        d_mo = min_ones;
        d_st = sec_tens;
        d_so = sec_ones;
        if (sec_ones != 4'd0) begin
            d_so = sec_ones - 4'd1;
        end else begin
            d_so = 4'd9;
            if (sec_tens != 4'd0) begin
                d_st = sec_tens - 4'd1;
            end else begin
                d_st = 4'd5;
                if (min_ones != 4'd0) begin
                    d_mo = min_ones - 4'd1;
                end else begin
                    d_mo = 4'd9;
                    d_mt = min_tens - 4'd1;
                end
            end
        end
    end

    assign dec_zero = (d_mt == 4'd0) && (d_mo == 4'd0) &&
                      (d_st == 4'd0) && (d_so == 4'd0);

    // Digit register, prescaler and done flag: reset > clear > count > entry
    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            presc      <= '0;
            timer_done <= 1'b0;
        end else if (run) begin
            if (tick) begin
                presc    <= '0;
                min_tens <= d_mt;
                min_ones <= d_mo;
                sec_tens <= d_st;
                sec_ones <= d_so;
                if (dec_zero) begin
                    timer_done <= 1'b1;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            if (time_zero) begin
                presc <= '0;
            end
            if (mag_on && time_zero) begin
                timer_done <= 1'b1;
            end else if (entry_ok) begin
                min_tens   <= min_ones;
                min_ones   <= sec_tens;
                sec_tens   <= sec_ones;
                sec_ones   <= digit;
                timer_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cook_timer_countdown.sv
// Directed bench for cook_timer_countdown with TICKS_PER_SEC = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cook_timer_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic       mag_on;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;
    logic [15:0] t;

    int checks = 0;
    int errors = 0;

    cook_timer_countdown #(.TICKS_PER_SEC(4)) dut (
        .clk(clk),
        .rst(rst),
        .clearn(clearn),
        .digit_valid(digit_valid),
        .digit(digit),
        .mag_on(mag_on),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .timer_done(timer_done)
    );

    always #5 clk = ~clk;

    assign t = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic clkn(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic enter(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        clk1();
        digit_valid = 1'b0;
    endtask

    task automatic load(input logic [15:0] v);
        mag_on = 1'b0;
        clearn = 1'b0;
        clk1();
        clearn = 1'b1;
        enter(v[15:12]);
        enter(v[11:8]);
        enter(v[7:4]);
        enter(v[3:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1; clearn = 1'b1; digit_valid = 1'b0;
        digit = 4'd0; mag_on = 1'b0;
        clkn(2);
        checks++;
        if (t !== 16'h0000 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got %h done %b want 0000 done 0", t, timer_done);
        end
        rst = 1'b0;
        load(16'h0130);
        mag_on = 1'b1;
        clkn(5);
        checks++;
        if (t !== 16'h0129) begin
            errors++;
            $display("FAIL reset_precount: got %h want 0129", t);
        end
        rst = 1'b1;
        clk1();
        checks++;
        if (t !== 16'h0000 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midcount: got %h done %b want 0000 done 0", t, timer_done);
        end
        mag_on = 1'b0;
        clk1();
        rst = 1'b0;
    endtask

    task automatic test_entry();
        load(16'h0000);
        enter(4'd1);
        enter(4'd3);
        enter(4'd0);
        enter(4'hA);
        checks++;
        if (t !== 16'h0130) begin
            errors++;
            $display("FAIL entry_shift: got %h want 0130", t);
        end
        enter(4'd7);
        checks++;
        if (t !== 16'h1307) begin
            errors++;
            $display("FAIL entry_discard_msd: got %h want 1307", t);
        end
    endtask

    task automatic test_countdown();
        load(16'h0002);
        mag_on = 1'b1;
        clkn(3);
        checks++;
        if (t !== 16'h0002) begin
            errors++;
            $display("FAIL count_3clk: got %h want 0002", t);
        end
        clk1();
        checks++;
        if (t !== 16'h0001 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL count_4clk: got %h done %b want 0001 done 0", t, timer_done);
        end
        clkn(3);
        checks++;
        if (t !== 16'h0001 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL count_7clk: got %h done %b want 0001 done 0", t, timer_done);
        end
        clk1();
        checks++;
        if (t !== 16'h0000 || timer_done !== 1'b1) begin
            errors++;
            $display("FAIL count_8clk: got %h done %b want 0000 done 1", t, timer_done);
        end
        mag_on = 1'b0;
        clkn(3);
        checks++;
        if (t !== 16'h0000 || timer_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got %h done %b want 0000 done 1", t, timer_done);
        end
    endtask

    task automatic test_borrow();
        logic [15:0] src [3];
        logic [15:0] exp [3];
        src[0] = 16'h0100; exp[0] = 16'h0059;
        src[1] = 16'h1000; exp[1] = 16'h0959;
        src[2] = 16'h0090; exp[2] = 16'h0089;
        for (int i = 0; i < 3; i++) begin
            load(src[i]);
            mag_on = 1'b1;
            clkn(4);
            mag_on = 1'b0;
            checks++;
            if (t !== exp[i] || timer_done !== 1'b0) begin
                errors++;
                $display("FAIL borrow_%0d: got %h done %b want %h done 0", i, t, timer_done, exp[i]);
            end
        end
    endtask

    task automatic test_pause();
        load(16'h0005);
        mag_on = 1'b1;
        clkn(2);
        mag_on = 1'b0;
        clkn(10);
        checks++;
        if (t !== 16'h0005) begin
            errors++;
            $display("FAIL pause_hold: got %h want 0005", t);
        end
        mag_on = 1'b1;
        clk1();
        checks++;
        if (t !== 16'h0005) begin
            errors++;
            $display("FAIL pause_resume1: got %h want 0005", t);
        end
        clk1();
        checks++;
        if (t !== 16'h0004) begin
            errors++;
            $display("FAIL pause_resume2: got %h want 0004", t);
        end
        mag_on = 1'b0;
    endtask

    task automatic test_edges();
        load(16'h0002);
        mag_on = 1'b1;
        clkn(3);
        clearn = 1'b0;
        clk1();
        checks++;
        if (t !== 16'h0000 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_on_tick: got %h done %b want 0000 done 0", t, timer_done);
        end
        clearn = 1'b1;
        mag_on = 1'b0;
        enter(4'd0); enter(4'd0); enter(4'd0); enter(4'd2);
        mag_on = 1'b1;
        clkn(3);
        checks++;
        if (t !== 16'h0002) begin
            errors++;
            $display("FAIL clear_presc_3clk: got %h want 0002", t);
        end
        clk1();
        checks++;
        if (t !== 16'h0001) begin
            errors++;
            $display("FAIL clear_presc_4clk: got %h want 0001", t);
        end
        load(16'h0030);
        mag_on = 1'b1;
        digit_valid = 1'b1; digit = 4'd7;
        clk1();
        checks++;
        if (t !== 16'h0030) begin
            errors++;
            $display("FAIL entry_while_on: got %h want 0030", t);
        end
        clkn(2);
        clk1();
        digit_valid = 1'b0;
        checks++;
        if (t !== 16'h0029) begin
            errors++;
            $display("FAIL entry_with_tick: got %h want 0029", t);
        end
        load(16'h0000);
        mag_on = 1'b1;
        clk1();
        checks++;
        if (timer_done !== 1'b1 || t !== 16'h0000) begin
            errors++;
            $display("FAIL empty_start: got %h done %b want 0000 done 1", t, timer_done);
        end
        mag_on = 1'b0;
        clk1();
        enter(4'd5);
        checks++;
        if (timer_done !== 1'b0 || t !== 16'h0005) begin
            errors++;
            $display("FAIL entry_clears_done: got %h done %b want 0005 done 0", t, timer_done);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_countdown();
        test_borrow();
        test_pause();
        test_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
